// File: rtl/conv_mac_ctrl.sv
// Sequencer for the convolution MAC datapath: walks (n,k) over Z[n] = sum X[k]*Y[n-k].
// Optional abort input enabled by defining CONV_MAC_CTRL_ABORT_EN.
module conv_mac_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] size_x_i,
    input  logic [ADDR_WIDTH-1:0] size_y_i,
`ifdef CONV_MAC_CTRL_ABORT_EN
    input  logic                  abort_i,
`endif
    output logic [ADDR_WIDTH-1:0] memx_addr_o,
    output logic [ADDR_WIDTH-1:0] memy_addr_o,
    output logic                  acc_clr_o,
    output logic                  acc_en_o,
    output logic [ADDR_WIDTH:0]   memz_addr_o,
    output logic                  memz_we_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned ZW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_FLUSH = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [ZW-1:0] n_q, n_d, k_q, k_d;
    logic [AW-1:0] x_q, x_d, y_q, y_d;
    logic [ZW-1:0] z_q, z_d;
    logic          clr_q, clr_d, en_q, en_d, we_q, we_d, busy_q, busy_d, done_q, done_d;

    logic [ZW-1:0] n_last, k_min, k_max, n_inc;

    // Term bounds for the current output index, in ZW bits so n+1 never wraps
    always_comb begin
        n_last = ZW'(sx_q) + ZW'(sy_q) - ZW'(2);
        n_inc  = n_q + ZW'(1);
        k_min  = (n_inc > ZW'(sy_q)) ? (n_inc - ZW'(sy_q)) : '0;
        k_max  = (n_q < ZW'(sx_q)) ? n_q : (ZW'(sx_q) - ZW'(1));
    end

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        n_d     = n_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sx_d    = size_x_i;
                    sy_d    = size_y_i;
                    n_d     = '0;
                    k_d     = '0;
                    state_d = (size_x_i == '0 || size_y_i == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                k_d     = k_min;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == k_max) begin
                    state_d = S_FLUSH;
                end else begin
                    k_d = k_q + ZW'(1);
                end
            end
            S_FLUSH: state_d = S_WRITE;
            S_WRITE: begin
                if (n_q == n_last) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + ZW'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The issue flag is the MAC state; acc_en follows it one stage later
        en_d = (state_q == S_MAC);

`ifdef CONV_MAC_CTRL_ABORT_EN
        if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
            n_d     = n_q;
            k_d     = k_q;
            en_d    = 1'b0;
        end
`endif

        if (state_d == S_MAC) begin
            x_d = AW'(k_d);
            y_d = AW'(n_d - k_d);
        end

        z_d    = n_d;
        clr_d  = (state_d == S_CLEAR);
        we_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_CLEAR) || (state_d == S_MAC) ||
                 (state_d == S_FLUSH) || (state_d == S_WRITE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            n_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            n_q     <= n_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign memx_addr_o = x_q;
    assign memy_addr_o = y_q;
    assign memz_addr_o = z_q;
    assign acc_clr_o   = clr_q;
    assign acc_en_o    = en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // An abort arriving during WRITE must kill the write in the same cycle
`ifdef CONV_MAC_CTRL_ABORT_EN
    assign memz_we_o = we_q & ~abort_i;
`else
    assign memz_we_o = we_q;
`endif

endmodule
